// File: rtl/datamemory.sv
// Byte-addressable RV32I data memory: clocked little-endian stores, combinational loads.
// Define DMEM_RESET_CLEAR_EN to have reset clear every byte; otherwise reset leaves the array alone.
`ifndef MEM_SIZE
`define MEM_SIZE 256
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif

module datamemory #(
    parameter int MEM_SIZE = `MEM_SIZE,
    parameter int DATA_W   = `INSTRUCTION_SIZE,
    localparam int AW      = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [AW-1:0]     address,
    input  logic [DATA_W-1:0] write_data,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] read_data
);

    logic [7:0]    mem_q [MEM_SIZE];
    logic [AW-1:0] byteAddr [4];
    logic [3:0]    byteEn;
    logic [7:0]    b0, b1, b2, b3;

    // Byte indices wrap naturally in AW bits, so unaligned accesses at the top roll over to 0.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byteAddr[k] = address + AW'(k);
        end
    end

    always_comb begin
        byteEn = 4'b0000;
        if (mem_write) begin
            case (funct3)
                3'b000:  byteEn = 4'b0001;
                3'b001:  byteEn = 4'b0011;
                3'b010:  byteEn = 4'b1111;
                default: byteEn = 4'b0000;
            endcase
        end
    end

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < MEM_SIZE; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (byteEn[k]) begin
                    mem_q[byteAddr[k]] <= write_data[8*k +: 8];
                end
            end
        end
    end
`else
    // No reset branch on the array so it stays mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                if (byteEn[k]) begin
                    mem_q[byteAddr[k]] <= write_data[8*k +: 8];
                end
            end
        end
    end
`endif

    assign b0 = mem_q[byteAddr[0]];
    assign b1 = mem_q[byteAddr[1]];
    assign b2 = mem_q[byteAddr[2]];
    assign b3 = mem_q[byteAddr[3]];

    always_comb begin
        read_data = '0;
        if (reset && mem_read) begin
            case (funct3)
                3'b000:  read_data = DATA_W'($signed(b0));
                3'b001:  read_data = DATA_W'($signed({b1, b0}));
                3'b010:  read_data = DATA_W'({b3, b2, b1, b0});
                3'b100:  read_data = DATA_W'(b0);
                3'b101:  read_data = DATA_W'({b1, b0});
                default: read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_datamemory.sv
// Self-checking bench for datamemory: directed load/store cases, randomized traffic against a byte-array model, reset handling.
// Build with the same DMEM_RESET_CLEAR_EN setting as the RTL.
module tb_datamemory;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [2:0]  funct3;
    logic [31:0] read_data;

    int total;
    int bad;

    logic [7:0] model [256];

    datamemory dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .funct3     (funct3),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected load value computed directly from the byte array and the ISA load rules.
    function automatic logic [31:0] modelLoad(input int addr, input logic [2:0] f3, input bit rd, input bit rstN);
        logic [7:0] by [4];
        for (int k = 0; k < 4; k++) by[k] = model[(addr + k) % 256];
        if (!rd || !rstN) return 32'h0;
        case (f3)
            3'b000:  return 32'($signed(by[0]));
            3'b001:  return 32'($signed({by[1], by[0]}));
            3'b010:  return {by[3], by[2], by[1], by[0]};
            3'b100:  return {24'h0, by[0]};
            3'b101:  return {16'h0, by[1], by[0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStore(input int addr, input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : (f3 == 3'b010) ? 4 : 0;
        for (int k = 0; k < n; k++) model[(addr + k) % 256] = wd[8*k +: 8];
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] wd, input logic [2:0] f3);
        mem_read   = rd;
        mem_write  = wr;
        address    = a;
        write_data = wd;
        funct3     = f3;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        total++;
        assert (read_data === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, read_data, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A clocked store: apply, take the edge, then mirror it in the model when reset is released.
    task automatic doStore(input logic [7:0] a, input logic [31:0] wd, input logic [2:0] f3);
        applyStimulus(1'b0, 1'b1, a, wd, f3);
        tick();
        if (reset) modelStore(a, f3, wd);
        mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rw;
        logic [7:0]  ra;
        logic [2:0]  rf;
        bit          rrd, rwr;

        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
        tick();

        applyStimulus(1'b1, 1'b1, 8'h00, 32'h12345678, 3'b010);
        checkOutput("reset_read_zero", 32'h0);
        tick();
        reset = 1'b1;
        mem_write = 1'b0;
        #1;

        // Give every byte a known value so the model is complete in either build.
        for (int i = 0; i < 64; i++) doStore(8'(4 * i), $urandom, 3'b010);

        doStore(8'h00, 32'hAABBCCDD, 3'b010);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        checkOutput("sw_lw", 32'hAABBCCDD);

        doStore(8'h10, 32'h0000BEEF, 3'b001);
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 3'b001);
        checkOutput("sh_lh", 32'hFFFFBEEF);
        applyStimulus(1'b1, 1'b0, 8'h10, 32'h0, 3'b101);
        checkOutput("sh_lhu", 32'h0000BEEF);

        doStore(8'h20, 32'h000000AA, 3'b000);
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 3'b000);
        checkOutput("sb_lb", 32'hFFFFFFAA);
        applyStimulus(1'b1, 1'b0, 8'h20, 32'h0, 3'b100);
        checkOutput("sb_lbu", 32'h000000AA);

        doStore(8'h30, 32'h11223344, 3'b010);
        doStore(8'h31, 32'h000000FF, 3'b000);
        applyStimulus(1'b1, 1'b0, 8'h30, 32'h0, 3'b010);
        checkOutput("partial_store", 32'h1122FF44);

        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0, 3'b010);
        checkOutput("read_gated", 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 3'b011);
        checkOutput("illegal_f3_read", 32'h0);
        doStore(8'h00, 32'h99999999, 3'b011);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        checkOutput("illegal_f3_store", 32'hAABBCCDD);

        doStore(8'hFE, 32'h55667788, 3'b010);
        applyStimulus(1'b1, 1'b0, 8'hFE, 32'h0, 3'b010);
        checkOutput("wrap_lw", 32'h55667788);
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 3'b001);
        checkOutput("wrap_low_half", 32'h00005566);

        // Random traffic; the pre-edge check also covers read-during-write returning old data.
        for (int i = 0; i < 300; i++) begin
            rrd = ($urandom_range(0, 3) != 0);
            rwr = $urandom_range(0, 1) == 1;
            ra  = 8'($urandom);
            rw  = $urandom;
            rf  = 3'($urandom_range(0, 7));
            applyStimulus(rrd, rwr, ra, rw, rf);
            checkOutput("rand_pre_edge", modelLoad(ra, rf, rrd, 1'b1));
            tick();
            if (rwr) modelStore(ra, rf, rw);
            checkOutput("rand_post_edge", modelLoad(ra, rf, rrd, 1'b1));
        end

        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h00, 32'hDEADBEEF, 3'b010);
        checkOutput("reset_gates_read", 32'h0);
        tick();
`ifdef DMEM_RESET_CLEAR_EN
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
`endif
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0, 3'b010);
        checkOutput("after_reset_lw0", modelLoad(0, 3'b010, 1'b1, 1'b1));
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            applyStimulus(1'b1, 1'b0, ra, 32'h0, 3'b010);
            checkOutput("after_reset_lw", modelLoad(ra, 3'b010, 1'b1, 1'b1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
